// File: rtl/spdif_frame_sequencer.sv
// Splits stereo sample pairs into alternating L/R sub-frame requests for the S/PDIF
// sub-frame encoder, tracking the 192-frame block and substituting silence on underrun.
module spdif_frame_sequencer #(
  parameter int FRAMES_PER_BLOCK = 192,
  parameter int CS_BITS          = 40,
  parameter int DATA_W           = 24
) (
  input  logic                     clk128,
  input  logic                     reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [DATA_W-1:0] i_left,
  input  logic signed [DATA_W-1:0] i_right,
  input  logic [CS_BITS-1:0]       i_channel_status,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_is_frame_start,
  output logic                     o_is_left,
  output logic signed [DATA_W-1:0] o_audio,
  output logic                     o_user,
  output logic                     o_control,
  output logic                     o_underrun
);

  localparam int FCNT_W   = (FRAMES_PER_BLOCK > 1) ? $clog2(FRAMES_PER_BLOCK) : 1;
  localparam int CS_IDX_W = (CS_BITS > 1) ? $clog2(CS_BITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} state_t;

  state_t                    state_q, state_d;
  logic                      pend_v_q, pend_v_d;
  logic signed [DATA_W-1:0]  pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic signed [DATA_W-1:0]  cur_l_q, cur_l_d, cur_r_q, cur_r_d;
  logic [FCNT_W-1:0]         fcnt_q, fcnt_d;
  logic [CS_BITS-1:0]        cs_q, cs_d;
  logic                      underrun_q, underrun_d;
  logic                      cs_bit;

  always_comb begin
    state_d    = state_q;
    pend_v_d   = pend_v_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    cur_l_d    = cur_l_q;
    cur_r_d    = cur_r_q;
    fcnt_d     = fcnt_q;
    cs_d       = cs_q;
    underrun_d = 1'b0;

    o_ready          = !pend_v_q;
    o_valid          = 1'b0;
    o_is_left        = 1'b0;
    o_is_frame_start = 1'b0;
    o_audio          = '0;
    o_user           = 1'b0;
    o_control        = 1'b0;
    o_underrun       = underrun_q;

    // Channel-status bits beyond CS_BITS are transmitted as zero.
    cs_bit = 1'b0;
    if (fcnt_q < FCNT_W'(CS_BITS)) cs_bit = cs_q[fcnt_q[CS_IDX_W-1:0]];

    // Accept and consume are mutually exclusive: accept needs an empty buffer.
    if (i_valid && !pend_v_q) begin
      pend_v_d = 1'b1;
      pend_l_d = i_left;
      pend_r_d = i_right;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_v_q) begin
          cur_l_d  = pend_l_q;
          cur_r_d  = pend_r_q;
          pend_v_d = 1'b0;
          fcnt_d   = '0;
          cs_d     = i_channel_status;
          state_d  = S_LEFT;
        end
      end
      S_LEFT: begin
        o_valid          = 1'b1;
        o_is_left        = 1'b1;
        o_audio          = cur_l_q;
        o_is_frame_start = (fcnt_q == '0);
        o_control        = cs_bit;
        if (i_ready) state_d = S_RIGHT;
      end
      S_RIGHT: begin
        o_valid   = 1'b1;
        o_audio   = cur_r_q;
        o_control = cs_bit;
        if (i_ready) begin
          if (pend_v_q) begin
            cur_l_d  = pend_l_q;
            cur_r_d  = pend_r_q;
            pend_v_d = 1'b0;
          end else begin
            cur_l_d    = '0;
            cur_r_d    = '0;
            underrun_d = 1'b1;
          end
          if (fcnt_q == FCNT_W'(FRAMES_PER_BLOCK - 1)) begin
            fcnt_d = '0;
            cs_d   = i_channel_status;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
          state_d = S_LEFT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk128) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pend_v_q   <= 1'b0;
      fcnt_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      fcnt_q     <= fcnt_d;
      underrun_q <= underrun_d;
    end
  end

  // Data registers are qualified by control state, so they carry no reset.
  always_ff @(posedge clk128) begin
    pend_l_q <= pend_l_d;
    pend_r_q <= pend_r_d;
    cur_l_q  <= cur_l_d;
    cur_r_q  <= cur_r_d;
    cs_q     <= cs_d;
  end

endmodule

// File: tb/tb_spdif_frame_sequencer.sv
// Bench for spdif_frame_sequencer: directed vector table, block/underrun/reset sequences
// and randomized traffic against a sub-frame-count reference model.
module tb_spdif_frame_sequencer;
  localparam int FPB = 192;
  localparam int CSB = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [23:0] i_left = '0;
  logic [23:0] i_right = '0;
  logic [39:0] i_cs = '0;
  logic        o_ready, o_valid, o_is_frame_start, o_is_left, o_user, o_control, o_underrun;
  logic [23:0] o_audio;

  always #5 clk = ~clk;

  spdif_frame_sequencer #(.FRAMES_PER_BLOCK(FPB), .CS_BITS(CSB), .DATA_W(24)) dut (
    .clk128(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_left(i_left), .i_right(i_right), .i_channel_status(i_cs),
    .o_valid(o_valid), .i_ready(i_ready), .o_is_frame_start(o_is_frame_start),
    .o_is_left(o_is_left), .o_audio(o_audio), .o_user(o_user),
    .o_control(o_control), .o_underrun(o_underrun)
  );

  int total = 0;
  int bad = 0;

  // Reference model: counts sub-frames since start; pairs waiting in a queue.
  bit          m_started, m_und, chk_en;
  int          m_k, pushes;
  logic [23:0] m_q_l[$], m_q_r[$];
  logic [23:0] m_cur_l, m_cur_r;
  logic [39:0] m_cs;
  logic [30:0] obs;
  int st_fs, st_c0, st_s0, st_c1, st_und, st_nz;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [30:0] pk(input bit v, rdy, lft, fs, ctl, und, input logic [23:0] a);
    return {v, rdy, lft, fs, 1'b0, ctl, und, a};
  endfunction

  function automatic logic [30:0] model_exp();
    int  fr;
    bit  lft, ctl;
    if (!m_started) return pk(1'b0, m_q_l.size() == 0, 1'b0, 1'b0, 1'b0, m_und, 24'h0);
    lft = (m_k % 2) == 0;
    fr  = (m_k / 2) % FPB;
    ctl = (fr < CSB) ? m_cs[fr] : 1'b0;
    return pk(1'b1, m_q_l.size() == 0, lft, lft && fr == 0, ctl, m_und,
              lft ? m_cur_l : m_cur_r);
  endfunction

  task automatic model_reset();
    m_started = 0; m_und = 0; m_k = 0; chk_en = 1;
    m_q_l.delete(); m_q_r.delete();
    m_cur_l = '0; m_cur_r = '0; m_cs = '0;
  endtask

  task automatic clear_stats();
    st_fs = 0; st_c0 = 0; st_s0 = 0; st_c1 = 0; st_und = 0; st_nz = 0; pushes = 0;
  endtask

  task automatic cycle(input bit rst, input bit v, input logic [23:0] l, input logic [23:0] r,
                       input bit rdy, input logic [39:0] cs);
    bit acc_ok, und_n;
    int fr;
    reset = rst; i_valid = v; i_left = l; i_right = r; i_ready = rdy; i_cs = cs;
    #4;
    obs = {o_valid, o_ready, o_is_left, o_is_frame_start, o_user, o_control, o_underrun, o_audio};
    if (chk_en) check("cycle_outputs", 64'(obs), 64'(model_exp()));
    if (o_valid && rdy) begin
      fr = (m_k / 2) % FPB;
      if (o_is_frame_start) st_fs++;
      if (o_control) begin
        if (m_k / 2 / FPB == 0) begin st_c0++; st_s0 += fr; end
        else st_c1++;
      end
      if ((m_k / 2) >= 4 && o_audio != 24'h0) st_nz++;
    end
    if (o_underrun) st_und++;
    acc_ok = (m_q_l.size() == 0);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      und_n = 0;
      if (!m_started) begin
        if (m_q_l.size() != 0) begin
          m_cur_l = m_q_l.pop_front(); m_cur_r = m_q_r.pop_front();
          m_started = 1; m_k = 0; m_cs = cs;
        end
      end else if (rdy) begin
        m_k++;
        if (m_k % 2 == 0) begin
          if (m_q_l.size() != 0) begin
            m_cur_l = m_q_l.pop_front(); m_cur_r = m_q_r.pop_front();
          end else begin
            m_cur_l = '0; m_cur_r = '0; und_n = 1;
          end
          if ((m_k / 2) % FPB == 0) m_cs = cs;
        end
      end
      if (v && acc_ok) begin m_q_l.push_back(l); m_q_r.push_back(r); pushes++; end
      m_und = und_n;
    end
    #1;
  endtask

  typedef struct {
    bit          v;
    logic [23:0] l, r;
    bit          rdy;
    logic [30:0] e;
  } vec_t;
  vec_t tbl[12];

  initial begin
    logic [39:0] cs_r;
    int cyc;
    tbl[0]  = '{1, 24'hFFFFF8, 24'h123456, 0, pk(0, 1, 0, 0, 0, 0, 24'h0)};
    tbl[1]  = '{0, 24'h0, 24'h0, 0, pk(0, 0, 0, 0, 0, 0, 24'h0)};
    tbl[2]  = '{0, 24'h0, 24'h0, 0, pk(1, 1, 1, 1, 0, 0, 24'hFFFFF8)};
    tbl[3]  = '{0, 24'h0, 24'h0, 1, pk(1, 1, 1, 1, 0, 0, 24'hFFFFF8)};
    tbl[4]  = '{0, 24'h0, 24'h0, 0, pk(1, 1, 0, 0, 0, 0, 24'h123456)};
    tbl[5]  = '{1, 24'h000001, 24'h7FFFFF, 1, pk(1, 1, 0, 0, 0, 0, 24'h123456)};
    tbl[6]  = '{0, 24'h0, 24'h0, 0, pk(1, 0, 1, 0, 0, 1, 24'h0)};
    tbl[7]  = '{0, 24'h0, 24'h0, 1, pk(1, 0, 1, 0, 0, 0, 24'h0)};
    tbl[8]  = '{0, 24'h0, 24'h0, 1, pk(1, 0, 0, 0, 0, 0, 24'h0)};
    tbl[9]  = '{0, 24'h0, 24'h0, 0, pk(1, 1, 1, 0, 0, 0, 24'h000001)};
    tbl[10] = '{0, 24'h0, 24'h0, 1, pk(1, 1, 1, 0, 0, 0, 24'h000001)};
    tbl[11] = '{0, 24'h0, 24'h0, 0, pk(1, 1, 0, 0, 0, 0, 24'h7FFFFF)};

    chk_en = 0;
    clear_stats();
    @(posedge clk); #1;

    // Reset, then idle for 100 clocks.
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) cycle(0, 0, 0, 0, i % 2 == 1, 40'hFF_FFFF_FFFF);
    check("idle_outputs", 64'(obs), 64'(pk(0, 1, 0, 0, 0, 0, 24'h0)));

    // Directed vector table: first pair, underrun, refill.
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].rdy, 40'h0);
      check($sformatf("vec%0d", i), 64'(obs), 64'(tbl[i].e));
    end

    // Full block plus one frame with continuous source; status changes mid-block.
    cycle(1, 0, 0, 0, 0, 0);
    clear_stats();
    cyc = 0;
    while (m_k < 2 * (FPB + 1) && cyc < 5000) begin
      cs_r = (m_started && m_k / 2 >= 100) ? 40'h00_0000_0001 : 40'h00_0200_0004;
      cycle(0, 1, 24'($urandom), 24'($urandom), $urandom_range(0, 1) == 1, cs_r);
      cyc++;
    end
    check("block_done", 64'(m_k), 64'(2 * (FPB + 1)));
    check("frame_start_cnt", 64'(st_fs), 64'd2);
    check("ctrl_blk0_cnt", 64'(st_c0), 64'd4);
    check("ctrl_blk0_frames", 64'(st_s0), 64'd54);
    check("ctrl_blk1_cnt", 64'(st_c1), 64'd2);

    // Source stops after four pairs; encoder pulls every 8 clocks.
    cycle(1, 0, 0, 0, 0, 0);
    clear_stats();
    cyc = 0;
    while (m_k < 24 && cyc < 2000) begin
      cycle(0, pushes < 4, 24'($urandom) | 24'h1, 24'($urandom) | 24'h1, cyc % 8 == 7,
            40'h0);
      cyc++;
    end
    cycle(0, 0, 0, 0, 0, 40'h0);
    check("underrun_done", 64'(m_k), 64'd24);
    check("underrun_pulses", 64'(st_und), 64'd9);
    check("silent_audio", 64'(st_nz), 64'd0);

    // Reset while in RIGHT with a pending pair.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 24'hABCDEF, 24'h654321, 0, 40'h0);
    cycle(0, 0, 0, 0, 0, 40'h0);
    cycle(0, 0, 0, 0, 1, 40'h0);
    cycle(0, 1, 24'h111111, 24'h222222, 0, 40'h0);
    cycle(1, 0, 0, 0, 0, 40'h0);
    check("pre_reset_right_pend", 64'(obs[30:28]), 64'(3'b100));
    cycle(0, 0, 0, 0, 1, 40'h0);
    check("post_reset_state", 64'(obs), 64'(pk(0, 1, 0, 0, 0, 0, 24'h0)));
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 40'h0);
    check("pending_discarded", 64'(obs[30]), 64'd0);

    // Randomized traffic with occasional status changes and resets.
    cycle(1, 0, 0, 0, 0, 0);
    cs_r = {8'($urandom), 32'($urandom)};
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) cs_r = {8'($urandom), 32'($urandom)};
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0, 24'($urandom),
            24'($urandom), $urandom_range(0, 1) == 1, cs_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
